// File: rtl/irq_pkg.sv
// Shared register map and data width for the interrupt controller.
package irq_pkg;

   localparam int IRQ_DATA_W = 32;

   localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
   localparam logic [1:0] IRQ_REG_MASK    = 2'd1;
   localparam logic [1:0] IRQ_REG_MODE    = 2'd2;
   localparam logic [1:0] IRQ_REG_STATUS  = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: polarity fix, synchroniser, history flop and
// registered rising-edge detect. level_out and edge_out are aligned so both
// describe the same synchronised sample.
module irq_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic INV         = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic src_in,
   output logic level_out,
   output logic edge_out
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   edge_q, edge_d;

   // next-state: shift the normalised source in, track last synced value
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], src_in ^ INV};
      hist_d = sync_q[SYNC_STAGES-1];
      edge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   // sync chain and history reset asserted so an already-active source never looks like an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         hist_q <= 1'b1;
         edge_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         edge_q <= edge_d;
      end
   end

   assign level_out = hist_q;
   assign edge_out  = edge_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: NUM_SRC conditioned sources, per-source pending latch
// (edge or level), mask, fixed-priority id and a four-register access port.
module irq_controller
   import irq_pkg::*;
#(
   parameter int                 NUM_SRC     = 8,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0] SRC_INV     = '0,
   localparam int                ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC-1:0]    src,
   input  logic                  reg_sel,
   input  logic                  reg_we,
   input  logic [1:0]            reg_addr,
   input  logic [IRQ_DATA_W-1:0] reg_wdata,
   output logic [IRQ_DATA_W-1:0] reg_rdata,
   output logic                  irq_out,
   output logic                  irq_pulse,
   output logic [ID_W-1:0]       irq_id
);

   logic [NUM_SRC-1:0]    src_level;
   logic [NUM_SRC-1:0]    src_edge;

   logic [NUM_SRC-1:0]    pending_q, pending_d;
   logic [NUM_SRC-1:0]    mask_q, mask_d;
   logic [NUM_SRC-1:0]    mode_q, mode_d;
   logic [IRQ_DATA_W-1:0] rdata_q, rdata_d;
   logic                  irq_out_q, irq_out_d;
   logic                  irq_pulse_q, irq_pulse_d;
   logic [ID_W-1:0]       irq_id_q, irq_id_d;

   logic                  wr_en, rd_en;
   logic [NUM_SRC-1:0]    wdata_src;
   logic [NUM_SRC-1:0]    w1c, sw_set, active;
   logic [IRQ_DATA_W-1:0] status_word;
   logic                  unused_wdata;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES),
         .INV         (SRC_INV[i])
      ) u_sync_edge (
         .clk       (clk),
         .reset     (reset),
         .src_in    (src[i]),
         .level_out (src_level[i]),
         .edge_out  (src_edge[i])
      );
   end

   assign wr_en        = reg_sel & reg_we;
   assign rd_en        = reg_sel & ~reg_we;
   assign wdata_src    = reg_wdata[NUM_SRC-1:0];
   assign unused_wdata = ^reg_wdata[IRQ_DATA_W-1:NUM_SRC];

   // register writes and pending update; in edge mode a set wins over a same-cycle clear
   always_comb begin
      w1c       = (wr_en && reg_addr == IRQ_REG_PENDING) ? wdata_src : '0;
      sw_set    = (wr_en && reg_addr == IRQ_REG_STATUS) ? (wdata_src & mode_q) : '0;
      pending_d = (mode_q & (src_edge | sw_set | (pending_q & ~w1c)))
                | (~mode_q & src_level);
      mask_d    = (wr_en && reg_addr == IRQ_REG_MASK) ? wdata_src : mask_q;
      mode_d    = (wr_en && reg_addr == IRQ_REG_MODE) ? wdata_src : mode_q;
   end

   // request, lowest-index priority and rising-edge pulse, all from registered state
   always_comb begin
      active    = pending_q & mask_q;
      irq_out_d = |active;
      irq_id_d  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) irq_id_d = ID_W'(i);
      end
      irq_pulse_d = irq_out_d & ~irq_out_q;
   end

   // read mux; rdata only moves on a read strobe and sees state from before this edge
   always_comb begin
      status_word                 = '0;
      status_word[IRQ_DATA_W-1]   = irq_out_q;
      status_word[ID_W-1:0]       = irq_id_q;
      rdata_d                     = rdata_q;
      if (rd_en) begin
         case (reg_addr)
            IRQ_REG_PENDING: rdata_d = IRQ_DATA_W'(pending_q);
            IRQ_REG_MASK:    rdata_d = IRQ_DATA_W'(mask_q);
            IRQ_REG_MODE:    rdata_d = IRQ_DATA_W'(mode_q);
            IRQ_REG_STATUS:  rdata_d = status_word;
            default:         rdata_d = rdata_q;
         endcase
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         mask_q      <= '0;
         mode_q      <= '1;
         rdata_q     <= '0;
         irq_out_q   <= 1'b0;
         irq_pulse_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         mode_q      <= mode_d;
         rdata_q     <= rdata_d;
         irq_out_q   <= irq_out_d;
         irq_pulse_q <= irq_pulse_d;
         irq_id_q    <= irq_id_d;
      end
   end

   assign reg_rdata = rdata_q;
   assign irq_out   = irq_out_q;
   assign irq_pulse = irq_pulse_q;
   assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register table, directed corner sequences and a
// randomized run checked every cycle against a delay-line reference model.
module tb_irq_controller;

   localparam logic [7:0] INV = 8'h40;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  src;
   logic        reg_sel;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        irq_out;
   logic        irq_pulse;
   logic [2:0]  irq_id;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   irq_controller #(
      .NUM_SRC     (8),
      .SYNC_STAGES (2),
      .SRC_INV     (INV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src       (src),
      .reg_sel   (reg_sel),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .irq_out   (irq_out),
      .irq_pulse (irq_pulse),
      .irq_id    (irq_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A source sampled at edge n becomes visible to the pending logic at edge n+3;
   // the line d0..d3 holds the normalised samples of the last four edges.
   logic [7:0]  d0 = 8'hFF, d1 = 8'hFF, d2 = 8'hFF, d3 = 8'hFF;
   logic [7:0]  m_pend, m_mask, m_mode;
   logic [31:0] m_rdata;
   logic        m_out, m_pulse;
   logic [2:0]  m_id;

   always @(posedge clk) begin : model
      logic [7:0] lvl, edg, w, act, np;
      int id;
      bit wr;
      if (reset) begin
         m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'hFF; m_rdata = 32'h0;
         m_out = 1'b0; m_pulse = 1'b0; m_id = 3'd0;
         d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF; d3 = 8'hFF;
      end else begin
         lvl = d2;
         edg = d2 & ~d3;
         w   = reg_wdata[7:0];
         wr  = reg_sel && reg_we;
         if (reg_sel && !reg_we) begin
            case (reg_addr)
               2'd0: m_rdata = {24'h0, m_pend};
               2'd1: m_rdata = {24'h0, m_mask};
               2'd2: m_rdata = {24'h0, m_mode};
               default: m_rdata = {m_out, 28'h0, m_id};
            endcase
         end
         act = m_pend & m_mask;
         id  = 0;
         for (int i = 7; i >= 0; i--) if (act[i]) id = i;
         m_pulse = (act != 8'h00) && !m_out;
         m_out   = (act != 8'h00);
         m_id    = id[2:0];
         for (int b = 0; b < 8; b++) begin
            if (m_mode[b]) begin
               if (edg[b] || (wr && reg_addr == 2'd3 && w[b])) np[b] = 1'b1;
               else if (wr && reg_addr == 2'd0 && w[b])        np[b] = 1'b0;
               else                                            np[b] = m_pend[b];
            end else begin
               np[b] = lvl[b];
            end
         end
         if (wr && reg_addr == 2'd1) m_mask = w;
         if (wr && reg_addr == 2'd2) m_mode = w;
         m_pend = np;
         d3 = d2; d2 = d1; d1 = d0; d0 = src ^ INV;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model irq_out",   {31'h0, irq_out},   {31'h0, m_out});
         chk("model irq_pulse", {31'h0, irq_pulse}, {31'h0, m_pulse});
         chk("model irq_id",    {29'h0, irq_id},    {29'h0, m_id});
         chk("model rdata",     reg_rdata,          m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input logic [7:0] s);
      src = s;
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] dat);
      reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = dat;
      tick();
      reg_sel = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] dat);
      reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
      tick();
      reg_sel = 1'b0;
      dat = reg_rdata;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[16];
   logic [31:0] r;

   initial begin
      reset = 1'b1; src = 8'h48; reg_sel = 1'b0; reg_we = 1'b0;
      reg_addr = 2'd0; reg_wdata = 32'h0;

      // reset values, with src[3] already active during reset
      ticks(3);
      chk_en = 1'b1;
      chk("reset irq_out",   {31'h0, irq_out},   32'h0);
      chk("reset irq_pulse", {31'h0, irq_pulse}, 32'h0);
      chk("reset irq_id",    {29'h0, irq_id},    32'h0);
      chk("reset rdata",     reg_rdata,          32'h0);
      reset = 1'b0;

      // active-at-reset source never fires in edge mode
      wr(2'd1, 32'hFF);
      ticks(6);
      chk("t1 irq_out", {31'h0, irq_out}, 32'h0);
      rd(2'd0, r);
      chk("t1 pending", r, 32'h0);

      // register table
      do_reset(8'h40);
      tbl[0]  = '{1'b0, 2'd2, 32'h0,        32'h0000_00FF};
      tbl[1]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0000};
      tbl[2]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
      tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
      tbl[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
      tbl[5]  = '{1'b0, 2'd1, 32'h0,        32'h0000_00FF};
      tbl[6]  = '{1'b1, 2'd2, 32'h0000_0F0F, 32'h0};
      tbl[7]  = '{1'b0, 2'd2, 32'h0,        32'h0000_000F};
      tbl[8]  = '{1'b1, 2'd2, 32'hFFFF_FF00, 32'h0};
      tbl[9]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
      tbl[10] = '{1'b1, 2'd2, 32'h0000_00FF, 32'h0};
      tbl[11] = '{1'b0, 2'd2, 32'h0,        32'h0000_00FF};
      tbl[12] = '{1'b1, 2'd1, 32'h0000_005A, 32'h0};
      tbl[13] = '{1'b0, 2'd1, 32'h0,        32'h0000_005A};
      tbl[14] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
      tbl[15] = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
         else begin
            rd(tbl[i].addr, r);
            chk($sformatf("tbl[%0d] rdata", i), r, tbl[i].exp);
         end
      end

      // edge latency, pulse, W1C
      do_reset(8'h40);
      wr(2'd1, 32'h01);
      ticks(2);
      src = 8'h41;                 // sampled at edge k
      ticks(4);                    // edges k..k+3
      chk("t2 irq_out k+3", {31'h0, irq_out}, 32'h0);
      rd(2'd0, r);                 // edge k+4
      chk("t2 pending", r, 32'h01);
      chk("t2 irq_out k+4",   {31'h0, irq_out},   32'h1);
      chk("t2 irq_pulse k+4", {31'h0, irq_pulse}, 32'h1);
      chk("t2 irq_id",        {29'h0, irq_id},    32'h0);
      tick();
      chk("t2 irq_pulse k+5", {31'h0, irq_pulse}, 32'h0);
      wr(2'd0, 32'h01);
      chk("t2 irq_out after w1c", {31'h0, irq_out}, 32'h1);
      tick();
      chk("t2 irq_out cleared", {31'h0, irq_out}, 32'h0);

      // priority
      wr(2'd1, 32'hFF);
      src = 8'h65;
      ticks(6);
      chk("t3 irq_id 2", {29'h0, irq_id}, 32'd2);
      wr(2'd0, 32'h04);
      tick();
      chk("t3 irq_id 5", {29'h0, irq_id}, 32'd5);
      wr(2'd0, 32'h20);
      tick();
      chk("t3 irq_out", {31'h0, irq_out}, 32'h0);

      // level mode bit 1
      wr(2'd2, 32'hFD);
      src = 8'h67;
      ticks(5);
      wr(2'd0, 32'h02);
      tick();
      rd(2'd0, r);
      chk("t4 level after w1c", r & 32'h2, 32'h2);
      src = 8'h65;                 // sampled at edge m
      ticks(3);                    // edges m..m+2
      rd(2'd0, r);                 // edge m+3 returns state after m+2
      chk("t4 level still set", r & 32'h2, 32'h2);
      rd(2'd0, r);
      chk("t4 level cleared", r & 32'h2, 32'h0);
      wr(2'd2, 32'hFF);

      // same-cycle edge and W1C on bit 4
      src = 8'h75;                 // sampled at edge k
      ticks(3);
      wr(2'd0, 32'h10);            // lands on edge k+3 with the set
      rd(2'd0, r);
      chk("t5 set beats w1c", r & 32'h10, 32'h10);

      // inverted source, software set, STATUS, mask drop
      wr(2'd0, 32'hFF);
      src = 8'h35;                 // src[6] 1->0 is an assertion
      ticks(5);
      wr(2'd3, 32'h80);
      wr(2'd1, 32'h40);
      ticks(2);
      rd(2'd0, r);
      chk("t6 pending", r, 32'hC0);
      rd(2'd3, r);
      chk("t6 status", r, 32'h8000_0006);
      wr(2'd1, 32'h00);
      tick();
      chk("mask drop irq_out", {31'h0, irq_out}, 32'h0);
      rd(2'd0, r);
      chk("mask drop pending kept", r, 32'hC0);

      // reset mid-operation
      wr(2'd1, 32'h40);
      ticks(2);
      chk("pre-reset irq_out", {31'h0, irq_out}, 32'h1);
      reset = 1'b1;
      tick();
      chk("mid reset irq_out", {31'h0, irq_out}, 32'h0);
      chk("mid reset rdata",   reg_rdata,        32'h0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post reset pulse", {31'h0, irq_pulse}, 32'h0);
      end

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) src = src ^ 8'(1 << $urandom_range(0, 7));
         reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 9) < 3) begin
            reg_sel   = 1'b1;
            reg_we    = 1'($urandom_range(0, 1));
            reg_addr  = 2'($urandom_range(0, 3));
            reg_wdata = $urandom;
         end else begin
            reg_sel = 1'b0;
            reg_we  = 1'b0;
         end
         tick();
      end
      reset = 1'b0; reg_sel = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
